// File: rtl/oscilo_pkg.sv
// Shared definitions for the oscilloscope command blocks.
// Holds the loader state encoding, the default inter-byte timeout and a
// helper that turns the framed LEN byte into a transfer count.
package oscilo_pkg;

    // 20 ms at 50 MHz
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1_000_000;

    // Remaining-byte counter must hold 256
    localparam int unsigned LEN_CNT_W = 9;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_GET_ADDR  = 4'd1,
        ST_GET_LEN   = 4'd2,
        ST_GET_DATA  = 4'd3,
        ST_WR_SETUP  = 4'd4,
        ST_WR_STROBE = 4'd5,
        ST_SEND_ACK  = 4'd6,
        ST_WAIT_TX   = 4'd7,
        ST_DONE      = 4'd8
    } loader_state_e;

    // A LEN byte of zero means a full 256-byte block
    function automatic logic [LEN_CNT_W-1:0] len_to_count(input logic [7:0] len);
        return (len == 8'd0) ? LEN_CNT_W'(256) : {1'b0, len};
    endfunction

endpackage

// File: rtl/sample_loader.sv
// sample_loader: receives ADDR, LEN, then LEN data bytes from the UART and
// writes them to sample memory at consecutive addresses, then returns the
// modulo-256 sum of the data bytes as an acknowledge byte.
// Ports:
//   clk_50mhz          sole clock, rising edge
//   reset              synchronous, active-low
//   activate / done    level enable in, transfer-finished level out
//   rx_data / rx_ready received UART byte and its valid (edge-detected)
//   tx_active          UART transmitter busy
//   tx_data / tx_start acknowledge byte and its transmit request
//   mem_clk / mem_we   write strobe and write enable to sample memory
//   mem_addr/mem_data  write address and data
module sample_loader
    import oscilo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                  clk_50mhz,
    input  logic                  reset,
    input  logic                  activate,
    output logic                  done,
    input  logic [7:0]            rx_data,
    input  logic                  rx_ready,
    input  logic                  tx_active,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    output logic                  mem_clk,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we
);

    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    loader_state_e          state_q, state_n;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_n;
    logic [LEN_CNT_W-1:0]   rem_q, rem_n;
    logic [7:0]             csum_q, csum_n;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_n;
    logic                   pend_q, pend_n;
    logic                   rx_prev_q;
    logic                   done_n, tx_start_n, mem_clk_n, mem_we_n;
    logic [7:0]             tx_data_n;
    logic [ADDR_WIDTH-1:0]  mem_addr_n;
    logic [DATA_WIDTH-1:0]  mem_data_n;

    logic rx_rise;
    logic timeout_hit;

    assign rx_rise     = rx_ready & ~rx_prev_q;
    assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Register stage: every output and all state update here
    always_ff @(posedge clk_50mhz) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            csum_q    <= '0;
            to_cnt_q  <= '0;
            pend_q    <= 1'b0;
            rx_prev_q <= 1'b0;
            done      <= 1'b0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            mem_clk   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
        end else begin
            state_q   <= state_n;
            addr_q    <= addr_n;
            rem_q     <= rem_n;
            csum_q    <= csum_n;
            to_cnt_q  <= to_cnt_n;
            pend_q    <= pend_n;
            rx_prev_q <= rx_ready;
            done      <= done_n;
            tx_start  <= tx_start_n;
            tx_data   <= tx_data_n;
            mem_clk   <= mem_clk_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_data  <= mem_data_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n    = state_q;
        addr_n     = addr_q;
        rem_n      = rem_q;
        csum_n     = csum_q;
        to_cnt_n   = '0;
        pend_n     = pend_q;
        done_n     = 1'b0;
        tx_start_n = 1'b0;
        tx_data_n  = tx_data;
        mem_clk_n  = 1'b0;
        mem_we_n   = 1'b0;
        mem_addr_n = mem_addr;
        mem_data_n = mem_data;

        case (state_q)
            ST_IDLE: begin
                pend_n = 1'b0;
                if (activate) begin
                    state_n = ST_GET_ADDR;
                end
            end

            ST_GET_ADDR: begin
                if (rx_rise) begin
                    addr_n  = ADDR_WIDTH'(rx_data);
                    state_n = ST_GET_LEN;
                end else if (timeout_hit) begin
                    state_n = ST_DONE;
                    done_n  = 1'b1;
                end else begin
                    to_cnt_n = to_cnt_q + TO_W'(1);
                end
            end

            ST_GET_LEN: begin
                if (rx_rise) begin
                    rem_n   = len_to_count(rx_data);
                    csum_n  = 8'd0;
                    pend_n  = 1'b0;
                    state_n = ST_GET_DATA;
                end else if (timeout_hit) begin
                    state_n = ST_DONE;
                    done_n  = 1'b1;
                end else begin
                    to_cnt_n = to_cnt_q + TO_W'(1);
                end
            end

            // A byte that arrived during the previous write is held in pend_q
            ST_GET_DATA: begin
                if (rx_rise || pend_q) begin
                    mem_data_n = DATA_WIDTH'(rx_data);
                    mem_addr_n = addr_q;
                    mem_we_n   = 1'b1;
                    csum_n     = csum_q + rx_data;
                    pend_n     = 1'b0;
                    state_n    = ST_WR_SETUP;
                end else if (timeout_hit) begin
                    state_n = ST_DONE;
                    done_n  = 1'b1;
                end else begin
                    to_cnt_n = to_cnt_q + TO_W'(1);
                end
            end

            ST_WR_SETUP: begin
                if (rx_rise) begin
                    pend_n = 1'b1;
                end
                mem_we_n  = 1'b1;
                mem_clk_n = 1'b1;
                state_n   = ST_WR_STROBE;
            end

            ST_WR_STROBE: begin
                if (rx_rise) begin
                    pend_n = 1'b1;
                end
                addr_n = addr_q + ADDR_WIDTH'(1);
                rem_n  = rem_q - LEN_CNT_W'(1);
                if (rem_q == LEN_CNT_W'(1)) begin
                    pend_n     = 1'b0;
                    tx_start_n = 1'b1;
                    tx_data_n  = csum_q;
                    state_n    = ST_SEND_ACK;
                end else begin
                    state_n = ST_GET_DATA;
                end
            end

            // Hold the request until the transmitter reports busy
            ST_SEND_ACK: begin
                if (tx_active) begin
                    state_n = ST_WAIT_TX;
                end else begin
                    tx_start_n = 1'b1;
                end
            end

            ST_WAIT_TX: begin
                if (!tx_active) begin
                    state_n = ST_DONE;
                    done_n  = 1'b1;
                end
            end

            ST_DONE: begin
                done_n = 1'b1;
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Losing activate aborts anything in progress, including a strobe
        if (!activate) begin
            state_n    = ST_IDLE;
            done_n     = 1'b0;
            tx_start_n = 1'b0;
            mem_clk_n  = 1'b0;
            mem_we_n   = 1'b0;
            pend_n     = 1'b0;
        end
    end

endmodule
